// File: rtl/cell_link_packet_rx.sv
// Purpose : terminal receiver for the forwarded cell-link stream; validates packets, writes payloads to a per-cell buffer.
// Latency : buffer write strobe/address/data one cycle after the payload word is accepted.
// Backpres: none; the input stream is always accepted, and bad or unwanted packets are dropped up to their TLAST.
//
// Ports
//   i_auroraUserClk / i_auroraUserReset : sole clock, synchronous active-high reset
//   i_auroraFAstrobe                    : one-cycle pulse at the start of each FA interval
//   i_cellMask                          : cells expected in the current interval
//   i_rxTVALID / i_rxTLAST / i_rxTDATA  : input stream (header word, PAYLOAD_WORDS payload words)
//   o_bufWrEnable / o_bufWrAddr / o_bufWrData : payload buffer write port, addr = {cellIndex, wordIndex}
//   o_cellValid                         : live bitmap of cells received intact this interval
//   o_intervalComplete                  : one-cycle pulse when every masked cell has arrived
//   o_snapBitmap / o_snap*              : bitmap and event counters captured at the last FA strobe
module cell_link_packet_rx #(
    parameter int MAX_CELLS        = 32,
    parameter int CELL_INDEX_WIDTH = 5,
    parameter int PAYLOAD_WORDS    = 8,
    parameter int WORD_INDEX_WIDTH = 3
) (
    input  logic                                       i_auroraUserClk,
    input  logic                                       i_auroraUserReset,
    input  logic                                       i_auroraFAstrobe,
    input  logic [MAX_CELLS-1:0]                       i_cellMask,
    input  logic                                       i_rxTVALID,
    input  logic                                       i_rxTLAST,
    input  logic [31:0]                                i_rxTDATA,
    output logic                                       o_bufWrEnable,
    output logic [CELL_INDEX_WIDTH+WORD_INDEX_WIDTH-1:0] o_bufWrAddr,
    output logic [31:0]                                o_bufWrData,
    output logic [MAX_CELLS-1:0]                       o_cellValid,
    output logic                                       o_intervalComplete,
    output logic [MAX_CELLS-1:0]                       o_snapBitmap,
    output logic [7:0]                                 o_snapGood,
    output logic [7:0]                                 o_snapMagicErr,
    output logic [7:0]                                 o_snapDupErr,
    output logic [7:0]                                 o_snapLenErr,
    output logic [7:0]                                 o_snapFlagErr
);

    localparam logic [15:0] LP_MAGIC = 16'hA5BE;
    localparam logic [CELL_INDEX_WIDTH:0] LP_MAX_CELLS = (CELL_INDEX_WIDTH + 1)'(MAX_CELLS);
    localparam logic [WORD_INDEX_WIDTH-1:0] LP_LAST_WORD = WORD_INDEX_WIDTH'(PAYLOAD_WORDS - 1);
    localparam logic [MAX_CELLS-1:0] LP_ONE_HOT0 = {{(MAX_CELLS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t                          r_state;
    logic [CELL_INDEX_WIDTH-1:0]     r_cellIndex;
    logic [WORD_INDEX_WIDTH-1:0]     r_wordIndex;
    // Set when a packet overran its payload length; the length error is
    // charged once the over-long packet's TLAST finally arrives.
    logic                            r_lenPend;

    logic                            r_bufWrEnable;
    logic [CELL_INDEX_WIDTH+WORD_INDEX_WIDTH-1:0] r_bufWrAddr;
    logic [31:0]                     r_bufWrData;

    logic [MAX_CELLS-1:0]            r_cellValid;
    logic                            r_intervalComplete;
    logic                            r_icArmed;

    logic [7:0]                      r_cntGood;
    logic [7:0]                      r_cntMagic;
    logic [7:0]                      r_cntDup;
    logic [7:0]                      r_cntLen;
    logic [7:0]                      r_cntFlag;

    logic [MAX_CELLS-1:0]            r_snapBitmap;
    logic [7:0]                      r_snapGood;
    logic [7:0]                      r_snapMagic;
    logic [7:0]                      r_snapDup;
    logic [7:0]                      r_snapLen;
    logic [7:0]                      r_snapFlag;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    state_t                          w_stateNext;
    logic [CELL_INDEX_WIDTH-1:0]     w_cellIndexNext;
    logic [WORD_INDEX_WIDTH-1:0]     w_wordIndexNext;
    logic                            w_lenPendNext;
    logic                            w_wrEn;
    logic                            w_evGood;
    logic                            w_evMagic;
    logic                            w_evDup;
    logic                            w_evLen;
    logic                            w_evFlag;

    logic [CELL_INDEX_WIDTH-1:0]     w_hdrIndex;
    logic                            w_hdrMagicBad;
    logic                            w_hdrIdxBad;
    logic                            w_hdrDup;
    logic [MAX_CELLS-1:0]            w_setMask;
    logic                            w_maskMet;

    assign w_hdrIndex    = i_rxTDATA[10 +: CELL_INDEX_WIDTH];
    assign w_hdrMagicBad = (i_rxTDATA[31:16] != LP_MAGIC);
    assign w_hdrIdxBad   = ({1'b0, w_hdrIndex} >= LP_MAX_CELLS);
    // Range is checked first so the bitmap is never indexed out of bounds.
    assign w_hdrDup      = w_hdrIdxBad || r_cellValid[w_hdrIndex];
    assign w_setMask     = LP_ONE_HOT0 << r_cellIndex;
    assign w_maskMet     = (i_cellMask != '0) && ((r_cellValid & i_cellMask) == i_cellMask);

    always_comb begin
        w_stateNext     = r_state;
        w_cellIndexNext = r_cellIndex;
        w_wordIndexNext = r_wordIndex;
        w_lenPendNext   = r_lenPend;
        w_wrEn          = 1'b0;
        w_evGood        = 1'b0;
        w_evMagic       = 1'b0;
        w_evDup         = 1'b0;
        w_evLen         = 1'b0;
        w_evFlag        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_rxTVALID) begin
                    if (i_rxTLAST) begin
                        // Header-only packet.
                        w_evLen = 1'b1;
                    end else if (w_hdrMagicBad) begin
                        w_evMagic     = 1'b1;
                        w_lenPendNext = 1'b0;
                        w_stateNext   = ST_DISCARD;
                    end else if (w_hdrDup) begin
                        w_evDup       = 1'b1;
                        w_lenPendNext = 1'b0;
                        w_stateNext   = ST_DISCARD;
                    end else begin
                        w_cellIndexNext = w_hdrIndex;
                        w_wordIndexNext = '0;
                        w_stateNext     = ST_PAYLOAD;
                    end
                end
            end

            ST_PAYLOAD: begin
                if (i_rxTVALID) begin
                    w_wrEn          = 1'b1;
                    w_wordIndexNext = r_wordIndex + 1'b1;
                    if (i_rxTLAST) begin
                        w_stateNext = ST_IDLE;
                        if (r_wordIndex == LP_LAST_WORD) begin
                            if (i_rxTDATA[31:30] == 2'b00) begin
                                w_evGood = 1'b1;
                            end else begin
                                w_evFlag = 1'b1;
                            end
                        end else begin
                            w_evLen = 1'b1;
                        end
                    end else if (r_wordIndex == LP_LAST_WORD) begin
                        // Packet is longer than the payload: stop writing,
                        // drain to TLAST and charge the error there.
                        w_lenPendNext = 1'b1;
                        w_stateNext   = ST_DISCARD;
                    end
                end
            end

            ST_DISCARD: begin
                if (i_rxTVALID && i_rxTLAST) begin
                    w_evLen       = r_lenPend;
                    w_lenPendNext = 1'b0;
                    w_stateNext   = ST_IDLE;
                end
            end

            default: begin
                w_lenPendNext = 1'b0;
                w_stateNext   = ST_IDLE;
            end
        endcase

        // An FA strobe splits whatever packet is in flight: the rest of it
        // is dropped silently (a header arriving with the strobe included).
        // Events raised in the strobe cycle are discarded in the register
        // block, so a final word here counts in neither interval, although
        // its buffer write still goes out.
        if (i_auroraFAstrobe) begin
            w_lenPendNext = 1'b0;
            if (w_stateNext == ST_PAYLOAD) begin
                w_stateNext = ST_DISCARD;
            end
        end
    end

    function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic en);
        return (en && (v != 8'hFF)) ? v + 8'd1 : v;
    endfunction

    // ------------------------------------------------------------------
    // State, write port, bitmap, counters
    // ------------------------------------------------------------------
    always_ff @(posedge i_auroraUserClk) begin
        if (i_auroraUserReset) begin
            r_state            <= ST_IDLE;
            r_cellIndex        <= '0;
            r_wordIndex        <= '0;
            r_lenPend          <= 1'b0;
            r_bufWrEnable      <= 1'b0;
            r_bufWrAddr        <= '0;
            r_bufWrData        <= '0;
            r_cellValid        <= '0;
            r_intervalComplete <= 1'b0;
            r_icArmed          <= 1'b1;
            r_cntGood          <= '0;
            r_cntMagic         <= '0;
            r_cntDup           <= '0;
            r_cntLen           <= '0;
            r_cntFlag          <= '0;
            r_snapBitmap       <= '0;
            r_snapGood         <= '0;
            r_snapMagic        <= '0;
            r_snapDup          <= '0;
            r_snapLen          <= '0;
            r_snapFlag         <= '0;
        end else begin
            r_state     <= w_stateNext;
            r_cellIndex <= w_cellIndexNext;
            r_wordIndex <= w_wordIndexNext;
            r_lenPend   <= w_lenPendNext;

            r_bufWrEnable <= w_wrEn;
            if (w_wrEn) begin
                r_bufWrAddr <= {r_cellIndex, r_wordIndex};
                r_bufWrData <= i_rxTDATA;
            end

            if (i_auroraFAstrobe) begin
                // Snapshots take the values as they stood before this cycle.
                r_snapBitmap       <= r_cellValid;
                r_snapGood         <= r_cntGood;
                r_snapMagic        <= r_cntMagic;
                r_snapDup          <= r_cntDup;
                r_snapLen          <= r_cntLen;
                r_snapFlag         <= r_cntFlag;
                r_cellValid        <= '0;
                r_cntGood          <= '0;
                r_cntMagic         <= '0;
                r_cntDup           <= '0;
                r_cntLen           <= '0;
                r_cntFlag          <= '0;
                r_intervalComplete <= 1'b0;
                r_icArmed          <= 1'b1;
            end else begin
                r_cntGood  <= sat_inc(r_cntGood,  w_evGood);
                r_cntMagic <= sat_inc(r_cntMagic, w_evMagic);
                r_cntDup   <= sat_inc(r_cntDup,   w_evDup);
                r_cntLen   <= sat_inc(r_cntLen,   w_evLen);
                r_cntFlag  <= sat_inc(r_cntFlag,  w_evFlag);
                if (w_evGood) begin
                    r_cellValid <= r_cellValid | w_setMask;
                end
                // Evaluated on the registered bitmap, so the pulse lands the
                // cycle after the completing bit becomes visible.
                if (r_icArmed && w_maskMet) begin
                    r_intervalComplete <= 1'b1;
                    r_icArmed          <= 1'b0;
                end else begin
                    r_intervalComplete <= 1'b0;
                end
            end
        end
    end

    assign o_bufWrEnable      = r_bufWrEnable;
    assign o_bufWrAddr        = r_bufWrAddr;
    assign o_bufWrData        = r_bufWrData;
    assign o_cellValid        = r_cellValid;
    assign o_intervalComplete = r_intervalComplete;
    assign o_snapBitmap       = r_snapBitmap;
    assign o_snapGood         = r_snapGood;
    assign o_snapMagicErr     = r_snapMagic;
    assign o_snapDupErr       = r_snapDup;
    assign o_snapLenErr       = r_snapLen;
    assign o_snapFlagErr      = r_snapFlag;

endmodule

// File: tb/tb_cell_link_packet_rx.sv
module tb_cell_link_packet_rx;

    logic        clk;
    logic        rst;
    logic        fa;
    logic [31:0] mask;
    logic        rx_vld;
    logic        rx_last;
    logic [31:0] rx_dat;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_dat;
    logic [31:0] cell_valid;
    logic        ic;
    logic [31:0] snap_bm;
    logic [7:0]  snap_good, snap_magic, snap_dup, snap_len, snap_flag;

    int n_chk = 0;
    int n_bad = 0;
    int ic_cnt = 0;
    logic [7:0]  wr_addr_q[$];
    logic [31:0] wr_dat_q[$];
    int s;

    cell_link_packet_rx dut (
        .i_auroraUserClk    (clk),
        .i_auroraUserReset  (rst),
        .i_auroraFAstrobe   (fa),
        .i_cellMask         (mask),
        .i_rxTVALID         (rx_vld),
        .i_rxTLAST          (rx_last),
        .i_rxTDATA          (rx_dat),
        .o_bufWrEnable      (wr_en),
        .o_bufWrAddr        (wr_addr),
        .o_bufWrData        (wr_dat),
        .o_cellValid        (cell_valid),
        .o_intervalComplete (ic),
        .o_snapBitmap       (snap_bm),
        .o_snapGood         (snap_good),
        .o_snapMagicErr     (snap_magic),
        .o_snapDupErr       (snap_dup),
        .o_snapLenErr       (snap_len),
        .o_snapFlagErr      (snap_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (wr_en) begin
            wr_addr_q.push_back(wr_addr);
            wr_dat_q.push_back(wr_dat);
        end
        if (ic) ic_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic logic [31:0] hdr(input logic [4:0] idx);
        return {16'hA5BE, 1'b0, idx, 10'h000};
    endfunction

    task automatic drive(input logic [31:0] d, input logic last, input logic strobe);
        rx_vld  = 1'b1;
        rx_last = last;
        rx_dat  = d;
        fa      = strobe;
        step();
        rx_vld  = 1'b0;
        rx_last = 1'b0;
        fa      = 1'b0;
    endtask

    // Header plus n_pl payload words; payload word i = {flags(last only), 6'h0, D0, cell, i}.
    // strobe_at: word position (0 = header) coinciding with an FA strobe, -1 none.
    // gap_at: position after which one idle cycle is inserted, -1 none.
    task automatic send_pkt(input logic [31:0] h, input int n_pl, input logic [1:0] fl,
                            input int strobe_at, input int gap_at);
        logic [4:0]  ci;
        logic [31:0] d;
        ci = h[14:10];
        for (int p = 0; p <= n_pl; p++) begin
            if (p == 0) d = h;
            else d = {(p == n_pl) ? fl : 2'b00, 6'h00, 8'hD0, {3'b000, ci}, 8'(p - 1)};
            drive(d, p == n_pl, p == strobe_at);
            if (p == gap_at) step();
        end
    endtask

    task automatic strobe();
        fa = 1'b1;
        step();
        fa = 1'b0;
    endtask

    initial begin
        rst = 1'b1; fa = 1'b0; mask = '0;
        rx_vld = 1'b0; rx_last = 1'b0; rx_dat = '0;
        idle(3);
        chk("rst_wr_en", {31'b0, wr_en}, 32'h0);
        chk("rst_cell_valid", cell_valid, 32'h0);
        chk("rst_ic", {31'b0, ic}, 32'h0);
        chk("rst_snap_bm", snap_bm, 32'h0);
        chk("rst_snap_good", {24'b0, snap_good}, 32'h0);
        rst = 1'b0;
        idle(2);

        // Good packet, cell 3, with a gap mid-payload.
        s = wr_addr_q.size();
        send_pkt(hdr(5'd3), 8, 2'b00, -1, 3);
        idle(2);
        chk("c3_nwr", wr_addr_q.size() - s, 8);
        for (int i = 0; i < 8; i++) chk("c3_addr", {24'b0, wr_addr_q[s+i]}, 32'h18 + i);
        chk("c3_last_dat", wr_dat_q[s+7], 32'h00D00307);
        chk("c3_valid", cell_valid, 32'h8);

        // Duplicate cell 3: no writes.
        s = wr_addr_q.size();
        send_pkt(hdr(5'd3), 8, 2'b00, -1, -1);
        idle(2);
        chk("dup_nwr", wr_addr_q.size() - s, 0);
        strobe();
        chk("s1_bm", snap_bm, 32'h8);
        chk("s1_good", {24'b0, snap_good}, 1);
        chk("s1_dup", {24'b0, snap_dup}, 1);
        chk("s1_live", cell_valid, 32'h0);

        // Bad magic, then flag error on cell 5.
        s = wr_addr_q.size();
        send_pkt(32'h5A5A0000, 8, 2'b00, -1, -1);
        idle(2);
        chk("magic_nwr", wr_addr_q.size() - s, 0);
        s = wr_addr_q.size();
        send_pkt(hdr(5'd5), 8, 2'b01, -1, -1);
        idle(2);
        chk("c5_nwr", wr_addr_q.size() - s, 8);
        chk("c5_last_dat", wr_dat_q[s+7], 32'h40D00507);
        chk("c5_valid", cell_valid, 32'h0);
        strobe();
        chk("s2_magic", {24'b0, snap_magic}, 1);
        chk("s2_flag", {24'b0, snap_flag}, 1);
        chk("s2_good", {24'b0, snap_good}, 0);
        chk("s2_dup", {24'b0, snap_dup}, 0);

        // Length errors: short, long, header-only; then a good cell 2.
        s = wr_addr_q.size();
        send_pkt(hdr(5'd2), 5, 2'b00, -1, -1);
        idle(2);
        chk("short_nwr", wr_addr_q.size() - s, 5);
        s = wr_addr_q.size();
        send_pkt(hdr(5'd2), 12, 2'b00, -1, -1);
        idle(2);
        chk("long_nwr", wr_addr_q.size() - s, 8);
        chk("long_last_addr", {24'b0, wr_addr_q[s+7]}, 32'h17);
        send_pkt(hdr(5'd2), 0, 2'b00, -1, -1);
        s = wr_addr_q.size();
        send_pkt(hdr(5'd2), 8, 2'b00, -1, -1);
        idle(2);
        chk("c2_nwr", wr_addr_q.size() - s, 8);
        chk("c2_valid", cell_valid, 32'h4);
        strobe();
        chk("s3_len", {24'b0, snap_len}, 3);
        chk("s3_good", {24'b0, snap_good}, 1);
        chk("s3_bm", snap_bm, 32'h4);

        // Interval completion with mask 0x7.
        mask = 32'h7;
        ic_cnt = 0;
        send_pkt(hdr(5'd0), 8, 2'b00, -1, -1);
        send_pkt(hdr(5'd2), 8, 2'b00, -1, -1);
        idle(3);
        chk("ic_before", ic_cnt, 0);
        send_pkt(hdr(5'd1), 8, 2'b00, -1, -1);
        chk("ic_not_yet", ic_cnt, 0);
        idle(3);
        chk("ic_after", ic_cnt, 1);
        chk("ic_valid", cell_valid, 32'h7);
        send_pkt(hdr(5'd3), 8, 2'b00, -1, -1);
        idle(3);
        chk("ic_once", ic_cnt, 1);

        // FA strobe mid-packet on cell 4: tail dropped, no error.
        s = wr_addr_q.size();
        send_pkt(hdr(5'd4), 8, 2'b00, 4, -1);
        idle(2);
        chk("mid_nwr", wr_addr_q.size() - s, 4);
        chk("s4_good", {24'b0, snap_good}, 4);
        chk("s4_bm", snap_bm, 32'hF);
        chk("mid_valid", cell_valid, 32'h0);
        chk("ic_rearm_quiet", ic_cnt, 1);

        // Final word coincides with strobe: written, counted nowhere.
        s = wr_addr_q.size();
        send_pkt(hdr(5'd6), 8, 2'b00, 8, -1);
        idle(2);
        chk("fin_nwr", wr_addr_q.size() - s, 8);
        chk("fin_valid", cell_valid, 32'h0);
        chk("s5_good", {24'b0, snap_good}, 0);
        chk("s5_len", {24'b0, snap_len}, 0);
        strobe();
        chk("s6_good", {24'b0, snap_good}, 0);
        chk("s6_bm", snap_bm, 32'h0);
        mask = '0;

        // Saturation: 300 bad-magic packets.
        for (int i = 0; i < 300; i++) send_pkt(32'h12340000, 1, 2'b00, -1, -1);
        strobe();
        chk("sat_magic", {24'b0, snap_magic}, 255);

        // Reset mid-packet.
        send_pkt(hdr(5'd1), 8, 2'b00, -1, -1);
        idle(1);
        chk("pre_rst_valid", cell_valid, 32'h2);
        drive(hdr(5'd7), 1'b0, 1'b0);
        drive(32'h11111111, 1'b0, 1'b0);
        drive(32'h22222222, 1'b0, 1'b0);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        chk("mr_valid", cell_valid, 32'h0);
        chk("mr_snap_magic", {24'b0, snap_magic}, 0);
        chk("mr_wr_en", {31'b0, wr_en}, 0);
        s = wr_addr_q.size();
        send_pkt(hdr(5'd7), 8, 2'b00, -1, -1);
        idle(2);
        chk("mr_c7_nwr", wr_addr_q.size() - s, 8);
        chk("mr_c7_first_addr", {24'b0, wr_addr_q[s]}, 32'h38);
        chk("mr_c7_valid", cell_valid, 32'h80);
        strobe();
        chk("mr_s_good", {24'b0, snap_good}, 1);
        chk("mr_s_bm", snap_bm, 32'h80);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
